// File: rtl/rnn_seq_ctrl_if.sv
// rnn_seq_ctrl_if: host, status and accelerator register-port signals of the RNN sequence controller.
// The master modport is the controller side; the slave modport is the host/accelerator side.
interface rnn_seq_ctrl_if;
    logic        emb_valid;
    logic [15:0] emb_data;
    logic        emb_ready;
    logic        start;
    logic [7:0]  seq_len;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic        result_pos;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport master (
        input  emb_valid, emb_data, start, seq_len, m_rdata,
        output emb_ready, busy, done, err, result, result_pos,
        output m_read, m_write, m_addr, m_wdata
    );

    modport slave (
        output emb_valid, emb_data, start, seq_len, m_rdata,
        input  emb_ready, busy, done, err, result, result_pos,
        input  m_read, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/rnn_seq_ctrl.sv
// rnn_seq_ctrl: buffers embedding elements and sequences an RNN accelerator through steps, dense and result read.
// Optional poll watchdog enabled by defining RNN_SEQ_TIMEOUT_EN (limit POLL_LIMIT consecutive polls).
module rnn_seq_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_LIMIT = 1024
) (
    input logic           clk,
    input logic           rst_n,
    rnn_seq_ctrl_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, FEED, KICK, WAIT_STEP, DENSE, WAIT_RES, READ, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  len_q, len_d, step_q, step_d;
    logic        err_q, err_d;
    logic [15:0] result_q, result_d;
    logic        pos_q, pos_d;
    logic        empty, full, push, pop, timeout;
    logic [15:0] head;
    logic        unused;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.emb_valid && !full;
    assign pop   = (state_q == FEED) && !empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign unused = ^bus.m_rdata[31:16];

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    // A watchdog abort discards everything queued, including a push in the same cycle.
    assign rd_ptr_d = timeout ? wr_ptr_d : rd_ptr_q + {{AW{1'b0}}, pop};

`ifdef RNN_SEQ_TIMEOUT_EN
    localparam int PW = $clog2(POLL_LIMIT + 1);
    logic [PW-1:0] poll_q, poll_d;
    logic          polling;

    assign polling = ((state_q == WAIT_STEP) || (state_q == WAIT_RES)) && !bus.m_rdata[0];
    assign poll_d  = polling ? poll_q + PW'(1) : '0;
    assign timeout = polling && (poll_q == PW'(POLL_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) poll_q <= '0;
        else        poll_q <= poll_d;
    end
`else
    localparam int UNUSED_POLL_LIMIT = POLL_LIMIT;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.emb_data;
    end

    // Port strobes depend only on registered state so the accelerator's read data never loops back.
    always_comb begin
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.m_addr  = 3'd0;
        bus.m_wdata = 32'd0;
        case (state_q)
            FEED: begin
                bus.m_write = !empty;
                bus.m_addr  = empty ? 3'd0 : 3'd1;
                bus.m_wdata = empty ? 32'd0 : {8'h00, 6'b0, idx_q, head};
            end
            KICK:      bus.m_write = 1'b1;
            WAIT_STEP: begin
                bus.m_read = 1'b1;
                bus.m_addr = 3'd1;
            end
            DENSE: begin
                bus.m_write = 1'b1;
                bus.m_addr  = 3'd7;
            end
            WAIT_RES:  bus.m_read = 1'b1;
            READ: begin
                bus.m_read = 1'b1;
                bus.m_addr = 3'd7;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        step_d   = step_q;
        err_d    = timeout;
        result_d = result_q;
        pos_d    = pos_q;
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.seq_len == 8'd0)) begin
                    err_d = 1'b1;
                end else if (bus.start) begin
                    state_d = FEED;
                    len_d   = bus.seq_len;
                    step_d  = 8'd0;
                    idx_d   = 2'd0;
                end
            end
            FEED: begin
                if (pop) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = (idx_q == 2'd3) ? KICK : FEED;
                end
            end
            KICK:  state_d = WAIT_STEP;
            WAIT_STEP: begin
                if (bus.m_rdata[0]) begin
                    step_d  = step_q + 8'd1;
                    idx_d   = 2'd0;
                    state_d = (step_q + 8'd1 == len_q) ? DENSE : FEED;
                end
            end
            DENSE: state_d = WAIT_RES;
            WAIT_RES: state_d = bus.m_rdata[0] ? READ : WAIT_RES;
            READ: begin
                result_d = bus.m_rdata[15:0];
                pos_d    = ~bus.m_rdata[15];
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idx_q    <= 2'd0;
            len_q    <= 8'd0;
            step_q   <= 8'd0;
            err_q    <= 1'b0;
            result_q <= 16'd0;
            pos_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            step_q   <= step_d;
            err_q    <= err_d;
            result_q <= result_d;
            pos_q    <= pos_d;
        end
    end

    assign bus.emb_ready  = !full;
    assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
    assign bus.done       = state_q == DONE;
    assign bus.err        = err_q;
    assign bus.result     = result_q;
    assign bus.result_pos = pos_q;
endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// tb_rnn_seq_ctrl: directed scenarios against a simple accelerator register model.
module tb_rnn_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rnn_seq_ctrl_if bus();

    rnn_seq_ctrl #(.FIFO_DEPTH(16), .POLL_LIMIT(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic        step_rdy = 1'b1;
    logic        res_rdy = 1'b1;
    logic [15:0] model_res = 16'h0000;

    assign bus.m_rdata = (bus.m_addr == 3'd1) ? {31'b0, step_rdy} :
                         (bus.m_addr == 3'd0) ? {31'b0, res_rdy} :
                         (bus.m_addr == 3'd7) ? {16'h0000, model_res} : 32'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int w1 = 0, w0 = 0, w7 = 0, r1 = 0, r0 = 0, r7 = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [2:0]  waq[$];
    logic [31:0] wdq[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.start && !bus.busy) start_cyc = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.err) err_cnt++;
        if (bus.m_read && bus.m_write) both_cnt++;
        if (bus.m_write) begin
            waq.push_back(bus.m_addr);
            wdq.push_back(bus.m_wdata);
            if (bus.m_addr == 3'd1) w1++;
            if (bus.m_addr == 3'd0) w0++;
            if (bus.m_addr == 3'd7) w7++;
        end
        if (bus.m_read) begin
            if (bus.m_addr == 3'd1) r1++;
            if (bus.m_addr == 3'd0) r0++;
            if (bus.m_addr == 3'd7) r7++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        bus.emb_valid = 1'b1;
        bus.emb_data  = v;
        step();
        bus.emb_valid = 1'b0;
    endtask

    task automatic kick(input logic [7:0] n);
        bus.start   = 1'b1;
        bus.seq_len = n;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        int k = 0;
        while (done_cnt < target && k < bound) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.err); end
        n_cmp++; if ({bus.m_read, bus.m_write} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got %b want 00", {bus.m_read, bus.m_write}); end
        n_cmp++; if (bus.m_addr !== 3'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", bus.m_addr); end
        n_cmp++; if (bus.m_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", bus.m_wdata); end
        n_cmp++; if (bus.result !== 16'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus.result); end
        n_cmp++; if (bus.result_pos !== 1'b0) begin n_bad++; $display("FAIL reset_result_pos got %b want 0", bus.result_pos); end
        n_cmp++; if (bus.emb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_emb_ready got %b want 1", bus.emb_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [2:0]  ea[6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd7};
        logic [31:0] ed[6] = '{32'h0000_0100, 32'h0001_0080, 32'h0002_FF00, 32'h0003_0000, 32'd0, 32'd0};
        int b0 = waq.size();
        int d0 = done_cnt;
        int rr7 = r7;
        step_rdy  = 1'b1;
        res_rdy   = 1'b1;
        model_res = 16'h0042;
        push(16'h0100);
        push(16'h0080);
        push(16'hFF00);
        push(16'h0000);
        kick(8'd1);
        wait_done(d0 + 1, 60);
        step();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if (waq.size() - b0 !== 6) begin n_bad++; $display("FAIL basic_write_count got %0d want 6", waq.size() - b0); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (waq[b0+i] !== ea[i]) begin n_bad++; $display("FAIL basic_waddr[%0d] got %0d want %0d", i, waq[b0+i], ea[i]); end
            n_cmp++; if (wdq[b0+i] !== ed[i]) begin n_bad++; $display("FAIL basic_wdata[%0d] got %h want %h", i, wdq[b0+i], ed[i]); end
        end
        n_cmp++; if (r7 - rr7 !== 1) begin n_bad++; $display("FAIL basic_read7_count got %0d want 1", r7 - rr7); end
        n_cmp++; if (done_cyc - start_cyc + 1 !== 11) begin n_bad++; $display("FAIL basic_latency got %0d want 11", done_cyc - start_cyc + 1); end
        n_cmp++; if (bus.result !== 16'h0042) begin n_bad++; $display("FAIL basic_result got %h want 0042", bus.result); end
        n_cmp++; if (bus.result_pos !== 1'b1) begin n_bad++; $display("FAIL basic_result_pos got %b want 1", bus.result_pos); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_stall();
        int b0 = waq.size();
        int d0 = done_cnt;
        int a1 = w1, a0 = w0, a7 = w7, bad_idx = 0, j = 0;
        model_res = 16'h1234;
        kick(8'd3);
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    push(16'h0010 + 16'(i));
                    repeat (4) step();
                end
            end
            wait_done(d0 + 1, 600);
        join
        step();
        for (int i = b0; i < waq.size(); i++) begin
            if (waq[i] == 3'd1) begin
                if (wdq[i] !== {14'b0, 2'(j), 16'h0010 + 16'(j)}) bad_idx++;
                j++;
            end
        end
        n_cmp++; if (w1 - a1 !== 12) begin n_bad++; $display("FAIL stall_addr1_writes got %0d want 12", w1 - a1); end
        n_cmp++; if (w0 - a0 !== 3) begin n_bad++; $display("FAIL stall_addr0_writes got %0d want 3", w0 - a0); end
        n_cmp++; if (w7 - a7 !== 1) begin n_bad++; $display("FAIL stall_addr7_writes got %0d want 1", w7 - a7); end
        n_cmp++; if (bad_idx !== 0) begin n_bad++; $display("FAIL stall_element_words got %0d wrong want 0", bad_idx); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL stall_done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if (bus.result !== 16'h1234) begin n_bad++; $display("FAIL stall_result got %h want 1234", bus.result); end
    endtask

    task automatic test_negative();
        int d0 = done_cnt;
        model_res = 16'hFF80;
        for (int i = 1; i <= 4; i++) push(16'(i));
        kick(8'd1);
        wait_done(d0 + 1, 60);
        step();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL neg_done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if (bus.result !== 16'hFF80) begin n_bad++; $display("FAIL neg_result got %h want ff80", bus.result); end
        n_cmp++; if (bus.result_pos !== 1'b0) begin n_bad++; $display("FAIL neg_result_pos got %b want 0", bus.result_pos); end
    endtask

    task automatic test_zero_len();
        int e0 = err_cnt;
        int b0 = waq.size();
        int rd0 = r0 + r1 + r7;
        kick(8'd0);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL zero_err_pulse got %b want 1", bus.err); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got %b want 0", bus.busy); end
        step();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL zero_err_clear got %b want 0", bus.err); end
        step();
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL zero_err_count got %0d want 1", err_cnt - e0); end
        n_cmp++; if ((waq.size() - b0) + (r0 + r1 + r7 - rd0) !== 0) begin n_bad++; $display("FAIL zero_port_txns got %0d want 0", (waq.size() - b0) + (r0 + r1 + r7 - rd0)); end
    endtask

    task automatic test_busy_start();
        int d0 = done_cnt;
        int a1 = w1, a0 = w0;
        step_rdy = 1'b0;
        model_res = 16'h0011;
        for (int i = 0; i < 4; i++) push(16'h0A00 + 16'(i));
        kick(8'd1);
        repeat (10) step();
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_during_run got %b want 1", bus.busy); end
        kick(8'd5);
        repeat (3) step();
        step_rdy = 1'b1;
        wait_done(d0 + 1, 60);
        repeat (5) step();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL busy_done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if (w0 - a0 !== 1) begin n_bad++; $display("FAIL busy_kick_writes got %0d want 1", w0 - a0); end
        n_cmp++; if (w1 - a1 !== 4) begin n_bad++; $display("FAIL busy_elem_writes got %0d want 4", w1 - a1); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_second_start_ignored got %b want 0", bus.busy); end
    endtask

    task automatic test_poll();
        int e0 = err_cnt;
        int p0 = r1;
        step_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h0B00 + 16'(i));
        kick(8'd1);
        repeat (120) step();
`ifdef RNN_SEQ_TIMEOUT_EN
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL poll_timeout_err got %0d want 1", err_cnt - e0); end
        n_cmp++; if (r1 - p0 !== 8) begin n_bad++; $display("FAIL poll_count got %0d want 8", r1 - p0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL poll_idle got %b want 0", bus.busy); end
`else
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL poll_no_err got %0d want 0", err_cnt - e0); end
        n_cmp++; if (r1 - p0 <= 100) begin n_bad++; $display("FAIL poll_continues got %0d polls want >100", r1 - p0); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL poll_still_busy got %b want 1", bus.busy); end
`endif
    endtask

    task automatic test_reset_mid();
        int d0, e0, b0;
        if (!bus.busy) begin
            step_rdy = 1'b0;
            for (int i = 0; i < 4; i++) push(16'h0C00 + 16'(i));
            kick(8'd1);
            repeat (10) step();
        end
        d0 = done_cnt;
        e0 = err_cnt;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        n_cmp++; if ({bus.m_read, bus.m_write} !== 2'b00) begin n_bad++; $display("FAIL rstmid_strobes got %b want 00", {bus.m_read, bus.m_write}); end
        n_cmp++; if (bus.m_addr !== 3'd0) begin n_bad++; $display("FAIL rstmid_addr got %0d want 0", bus.m_addr); end
        n_cmp++; if (bus.result !== 16'd0) begin n_bad++; $display("FAIL rstmid_result got %h want 0", bus.result); end
        n_cmp++; if (bus.result_pos !== 1'b0) begin n_bad++; $display("FAIL rstmid_result_pos got %b want 0", bus.result_pos); end
        step();
        step();
        rst_n = 1'b1;
        step();
        step_rdy  = 1'b1;
        model_res = 16'h0007;
        b0 = waq.size();
        for (int i = 0; i < 4; i++) push(16'h0D00 + 16'(i));
        kick(8'd1);
        wait_done(d0 + 1, 60);
        step();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL rstmid_done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL rstmid_err_count got %0d want 0", err_cnt - e0); end
        n_cmp++; if (waq.size() - b0 !== 6) begin n_bad++; $display("FAIL rstmid_write_count got %0d want 6", waq.size() - b0); end
        n_cmp++; if (wdq[b0] !== 32'h0000_0D00) begin n_bad++; $display("FAIL rstmid_first_elem got %h want 00000d00", wdq[b0]); end
        n_cmp++; if (bus.result !== 16'h0007) begin n_bad++; $display("FAIL rstmid_result_after got %h want 0007", bus.result); end
    endtask

    initial begin
        bus.emb_valid = 1'b0;
        bus.emb_data  = 16'h0000;
        bus.start     = 1'b0;
        bus.seq_len   = 8'd0;
        test_reset();
        test_basic();
        test_stall();
        test_negative();
        test_zero_len();
        test_busy_start();
        test_poll();
        test_reset_mid();
        n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL strobe_exclusive got %0d overlaps want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/rnn_seq_ctrl.md
RNN_SEQ_CTRL -- requirements
Module: rnn_seq_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, embedding-element FIFO depth (power of 2, >=4).
REQ-002 Parameter POLL_LIMIT, default 1024, max poll cycles per wait state (used only with RNN_SEQ_TIMEOUT_EN).
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 emb_valid  in  1  host offers one Q8.8 embedding element.
REQ-006 emb_data  in  16  embedding element value.
REQ-007 emb_ready  out  1  FIFO not full; element accepted when emb_valid&&emb_ready.
REQ-008 start  in  1  one-cycle pulse; begins a sequence run.
REQ-009 seq_len  in  8  number of characters (4 elements each), sampled on start.
REQ-010 busy  out  1  high from accepted start until done/err.
REQ-011 done  out  1  one-cycle pulse; result valid.
REQ-012 err  out  1  one-cycle pulse; run aborted.
REQ-013 result  out  16  signed inference result, held until next done.
REQ-014 result_pos  out  1  result >= 0, held with result.
REQ-015 m_read, m_write  out  1 each  accelerator register-port strobes, never both high.
REQ-016 m_addr  out  3  accelerator register address.
REQ-017 m_wdata  out  32  accelerator write data; m_rdata  in  32  read data, valid same cycle as m_read.

Function
REQ-018 FIFO shall accept pushes in any state, including during reset release; simultaneous push and pop permitted when not empty.
REQ-019 States IDLE, FEED, KICK, WAIT_STEP, DENSE, WAIT_RES, READ, DONE; start accepted only in IDLE; start while busy ignored.
REQ-020 start with seq_len==0 shall pulse err next cycle, no port transactions.
REQ-021 FEED: each cycle FIFO non-empty, pop one element and write m_addr=1, m_wdata={8'h00,6'b0,idx[1:0],value}, idx 0..3; FIFO empty stalls with strobes low.
REQ-022 After idx 3 write, KICK: one cycle write m_addr=0, m_wdata=0.
REQ-023 WAIT_STEP: from cycle after KICK, m_read with m_addr=1 every cycle; on m_rdata[0]==1 increment step count; go DENSE if count==seq_len else FEED (idx reset 0).
REQ-024 DENSE: one cycle write m_addr=7, m_wdata=0.
REQ-025 WAIT_RES: m_read m_addr=0 each cycle until m_rdata[0]==1, then READ.
REQ-026 READ: one cycle m_read m_addr=7; register result=m_rdata[15:0], result_pos=~m_rdata[15].
REQ-027 DONE: pulse done one cycle, busy low in same cycle, return IDLE.
REQ-028 Minimum latency start->done for seq_len=1 with FIFO pre-filled and 1-cycle step completion: 11 cycles.
REQ-029 Step counter 8 bits, no wrap: seq_len=255 completes 255 steps.

Reset
REQ-030 rst_n low: state IDLE, FIFO empty, counters 0, result 0, result_pos 0, busy/done/err/m_read/m_write 0, m_addr 0, m_wdata 0.
REQ-031 Reset mid-run shall abandon the run immediately; no done or err pulse.

Configuration
REQ-032 Macro RNN_SEQ_TIMEOUT_EN defined: WAIT_STEP/WAIT_RES exceeding POLL_LIMIT consecutive polls pulse err, flush FIFO, return IDLE.
REQ-033 Macro undefined: no watchdog; wait states poll indefinitely, err raised only by REQ-020.

Verification
REQ-034 Push 4 elements 0x0100,0x0080,0xFF00,0x0000, start seq_len=1, model returns result 0x0042 -> writes addr1 idx0..3, addr0, addr7, read addr7, done, result=0x0042, result_pos=1.
REQ-035 seq_len=3, elements pushed one per 5 cycles -> FEED stalls on empty, exactly 12 addr1 writes, 3 addr0 writes, one done.
REQ-036 Model result 0xFF80 -> result=0xFF80, result_pos=0.
REQ-037 start seq_len=0 -> err pulse next cycle, no strobes; second start during busy -> ignored.
REQ-038 RNN_SEQ_TIMEOUT_EN, POLL_LIMIT=8, model never ready -> err after 8 polls, FIFO empty, IDLE; without macro -> polling continues past 100 cycles.
REQ-039 rst_n low during WAIT_STEP -> all outputs 0 asynchronously, next start runs cleanly.
